chip8_draw_engine: RTL and testbench

Sprite-draw and screen-clear engine for the Chip-8 core: the responder side of the CPU's `DXYN` / `00E0` display requests. It owns the 64x32 monochrome framebuffer, fetches sprite bytes from program RAM, XORs them into the framebuffer with clipping, and reports the VF collision flag. A registered row-read port feeds the display scan-out logic.

---
 rtl/chip8_draw_engine.sv | 130 +++++++++++++
 tb/tb_chip8_draw_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_draw_engine.sv
// Chip-8 DXYN/00E0 responder that owns the 64x32 framebuffer and returns the VF collision flag.
// Draw busy 2R+1 cycles, clear 33; one-cycle sprite read latency; requests ignored unless idle.
module chip8_draw_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_clear,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [3:0]  req_n,
    input  logic [11:0] req_i,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        done,
    output logic        collision,
    input  logic [4:0]  disp_row,
    output logic [63:0] disp_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_XOR,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [63:0] fb [32];
    logic [7:0]  x0, y0, rows, row_cnt;
    logic [11:0] base;

    logic [7:0]  x_mod, y_mod, space, n_ext, rows_in, draw_row;
    logic [63:0] mask, cur_row;

    // Coordinates wrap at the screen size; the sprite height clips at the bottom edge.
    assign x_mod    = req_x & 8'h3F;
    assign y_mod    = req_y & 8'h1F;
    assign space    = 8'd32 - y_mod;
    assign n_ext    = {4'b0, req_n};
    assign rows_in  = (n_ext < space) ? n_ext : space;
    assign draw_row = y0 + row_cnt;
    assign mask     = {mem_rdata, 56'b0} >> x0;
    assign mem_addr = base + {4'b0, row_cnt};

    always_comb begin
        cur_row = '0;
        for (int k = 0; k < 32; k++) begin
            if (draw_row == 8'(k)) cur_row = fb[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_clear)             state_nx = S_CLEAR;
                    else if (rows_in == 8'd0)  state_nx = S_DONE;
                    else                       state_nx = S_FETCH;
                end
            end
            S_CLEAR: if (row_cnt == 8'd31) state_nx = S_DONE;
            S_FETCH: begin
                mem_rd   = 1'b1;
                state_nx = S_XOR;
            end
            S_XOR: state_nx = (row_cnt == rows - 8'd1) ? S_DONE : S_FETCH;
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0        <= '0;
            y0        <= '0;
            rows      <= '0;
            row_cnt   <= '0;
            base      <= '0;
            collision <= 1'b0;
            disp_data <= '0;
            for (int k = 0; k < 32; k++) fb[k] <= '0;
        end else begin
            // Non-blocking read gives the pre-write row when scan-out and a write collide.
            disp_data <= fb[disp_row];
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        x0        <= x_mod;
                        y0        <= y_mod;
                        rows      <= rows_in;
                        base      <= req_i;
                        row_cnt   <= '0;
                        collision <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    for (int k = 0; k < 32; k++) begin
                        if (row_cnt == 8'(k)) fb[k] <= '0;
                    end
                    row_cnt <= row_cnt + 8'd1;
                end
                S_XOR: begin
                    for (int k = 0; k < 32; k++) begin
                        if (draw_row == 8'(k)) fb[k] <= fb[k] ^ mask;
                    end
                    collision <= collision | (|(cur_row & mask));
                    row_cnt   <= row_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_draw_engine.sv
// Bench for chip8_draw_engine: directed and random draws against a pixel-level screen model.
module tb_chip8_draw_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_clear;
    logic [7:0]  req_x, req_y;
    logic [3:0]  req_n;
    logic [11:0] req_i;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        done, collision;
    logic [4:0]  disp_row;
    logic [63:0] disp_data;

    always #5 clk = ~clk;

    chip8_draw_engine dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_clear(req_clear),
        .req_x(req_x), .req_y(req_y), .req_n(req_n), .req_i(req_i),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .done(done), .collision(collision),
        .disp_row(disp_row), .disp_data(disp_data)
    );

    logic [7:0]  ram [4096];
    logic [63:0] model_fb [32];
    logic [11:0] exp_addrs [$];
    int          exp_rows;
    logic        exp_coll;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 32; k++) model_fb[k] = '0;
        exp_addrs.delete();
        exp_rows = 0;
        exp_coll = 1'b0;
    endtask

    // Pixel-by-pixel: column c lives at bit 63-c; pixels off-screen are dropped.
    task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                              input logic [11:0] i);
        int x0, y0, col;
        logic [11:0] a;
        logic [7:0]  b;
        x0 = int'(x) % 64;
        y0 = int'(y) % 32;
        exp_addrs.delete();
        exp_rows = 0;
        exp_coll = 1'b0;
        for (int r = 0; r < int'(n); r++) begin
            if (y0 + r >= 32) break;
            a = 12'((int'(i) + r) % 4096);
            exp_addrs.push_back(a);
            exp_rows++;
            b = ram[a];
            for (int c = 0; c < 8; c++) begin
                col = x0 + c;
                if (col < 64 && b[7-c]) begin
                    if (model_fb[y0+r][63-col]) exp_coll = 1'b1;
                    model_fb[y0+r][63-col] = ~model_fb[y0+r][63-col];
                end
            end
        end
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < 32; k++) begin
            disp_row = 5'(k);
            @(negedge clk);
            chk($sformatf("%s_row%0d", tag, k), disp_data, model_fb[k]);
        end
    endtask

    task automatic run_req(input string tag, input logic clr, input logic [7:0] x,
                           input logic [7:0] y, input logic [3:0] n, input logic [11:0] i,
                           input logic hold);
        logic [11:0] got_addrs [$];
        int done_t, busy_rdy, w, exp_done, m;
        if (clr) model_clear();
        else     model_draw(x, y, n, i);
        exp_done = clr ? 32 : 2 * exp_rows;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_clear = clr;
        req_x = x;
        req_y = y;
        req_n = n;
        req_i = i;
        @(posedge clk);
        #1;
        if (hold) begin
            req_clear = 1'b0;
            req_x = 8'($urandom);
            req_y = 8'($urandom_range(0, 20));
            req_n = 4'hF;
            req_i = 12'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        done_t = -1;
        busy_rdy = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (mem_rd) got_addrs.push_back(mem_addr);
            if (req_ready) busy_rdy++;
            if (done) begin
                done_t = t;
                break;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_done_cycle"}, 64'(done_t), 64'(exp_done));
        chk({tag, "_ready_while_busy"}, 64'(busy_rdy), 64'd0);
        chk({tag, "_collision"}, 64'(collision), 64'(exp_coll));
        chk({tag, "_reads"}, 64'(got_addrs.size()), 64'(exp_addrs.size()));
        m = (got_addrs.size() < exp_addrs.size()) ? got_addrs.size() : exp_addrs.size();
        for (int k = 0; k < m; k++)
            chk($sformatf("%s_addr%0d", tag, k), 64'(got_addrs[k]), 64'(exp_addrs[k]));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_collision_hold"}, 64'(collision), 64'(exp_coll));
        chk({tag, "_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
        reset = 1'b1;
        req_valid = 1'b0;
        req_clear = 1'b0;
        req_x = '0;
        req_y = '0;
        req_n = '0;
        req_i = '0;
        disp_row = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_collision", 64'(collision), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        sweep("rst");

        ram[0] = 8'hF0; ram[1] = 8'h90; ram[2] = 8'h90; ram[3] = 8'h90; ram[4] = 8'hF0;
        run_req("font0", 1'b0, 8'd0, 8'd0, 4'd5, 12'h000, 1'b0);
        sweep("font0");
        run_req("repeat", 1'b0, 8'd0, 8'd0, 4'd5, 12'h000, 1'b0);
        sweep("repeat");

        for (int a = 12'h200; a < 12'h205; a++) ram[a] = 8'hFF;
        run_req("clip", 1'b0, 8'd60, 8'd30, 4'd5, 12'h200, 1'b0);
        sweep("clip");

        ram[12'hFFF] = 8'h80;
        ram[12'h000] = 8'h80;
        run_req("wrap", 1'b0, 8'd70, 8'd33, 4'd2, 12'hFFF, 1'b0);
        sweep("wrap");

        run_req("nrows0", 1'b0, 8'd5, 8'd7, 4'd0, 12'h123, 1'b0);
        run_req("clr_hold", 1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1);
        sweep("clr_hold");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                run_req("rnd_clr", 1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0);
            end else begin
                for (int j = 0; j < 8; j++) ram[$urandom_range(0, 4095)] = 8'($urandom);
                run_req("rnd", 1'b0, 8'($urandom), 8'($urandom), 4'($urandom),
                        12'($urandom_range(0, 63)), 1'b0);
            end
            if (it % 4 == 3) sweep("rnd");
        end

        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_clear = 1'b0;
        req_x = 8'd3;
        req_y = 8'd2;
        req_n = 4'd5;
        req_i = 12'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd1);
        chk("midrst_mem_rd", 64'(mem_rd), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_collision", 64'(collision), 64'd0);
        chk("midrst_disp", disp_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        sweep("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
